spim_trace_buffer: RTL and testbench

- Downstream consumer of the single-cycle processor's debug outputs: pc, instruction, alu_result, read_data_2, branch, zero, memwrite and regwrite.
- On each retire strobe, captures one trace record into an internal FIFO if it passes the selected filter.
- Records drain through a valid/ready port to a host or logic-analyzer interface.
- Overflow is counted, never blocks the processor.

---
 rtl/spim_trace_pkg.sv | 28 ++
 rtl/spim_trace_fifo.sv | 68 ++++++
 rtl/spim_trace_buffer.sv | 125 ++++++++++++
 tb/tb_spim_trace_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spim_trace_pkg.sv
// Shared widths, filter encodings and the packed trace record for the SPIM trace buffer.
package spim_trace_pkg;

  localparam int PC_W   = 10;
  localparam int WORD_W = 32;
  localparam int FLAG_W = 4;

  localparam logic [1:0] FILT_ALL  = 2'b00;
  localparam logic [1:0] FILT_MEMW = 2'b01;
  localparam logic [1:0] FILT_BR   = 2'b10;
  localparam logic [1:0] FILT_REGW = 2'b11;

  localparam int FLAG_TAKEN = 3;
  localparam int FLAG_BR    = 2;
  localparam int FLAG_MEMW  = 1;
  localparam int FLAG_REGW  = 0;

  // Timestamp, when built in, is prepended above this record in the FIFO word.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/spim_trace_fifo.sv
// Generic synchronous FIFO with a registered head word; fill counts every stored entry,
// including the one currently presented on rdata.
module spim_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
  logic [FW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] head_q, head_next;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = head_q;
  assign fill  = cnt;

  always_comb begin
    wr_next  = wr_ptr + AW'(do_push);
    rd_next  = rd_ptr + AW'(do_pop);
    cnt_next = cnt + FW'(do_push) - FW'(do_pop);
    // A sole entry written this cycle is not in mem yet, so forward it into the head register.
    if (cnt_next == '0)
      head_next = '0;
    else if (do_push && (rd_next == wr_ptr))
      head_next = wdata;
    else
      head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      cnt    <= cnt_next;
      head_q <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clear && do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spim_trace_buffer.sv
// Filtered retire-trace capture with valid/ready drain and saturating drop accounting.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running timestamp stored with each record.
module spim_trace_buffer
  import spim_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16,
  parameter int TS_W   = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       retire_valid,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [WORD_W-1:0]          instruction_in,
  input  logic [WORD_W-1:0]          alu_result_in,
  input  logic [WORD_W-1:0]          store_data_in,
  input  logic                       branch_in,
  input  logic                       zero_in,
  input  logic                       memwrite_in,
  input  logic                       regwrite_in,
  input  logic                       trace_en,
  input  logic [1:0]                 filt_mode,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [WORD_W-1:0]          out_instr,
  output logic [WORD_W-1:0]          out_data,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int FIFO_W = REC_W + TS_W;
`else
  localparam int FIFO_W = REC_W;
`endif

  logic             taken, match, push_req, pop, full, empty;
  trace_rec_t       rec, head_rec;
  logic [FIFO_W-1:0] wdata, head;

  assign taken = branch_in & zero_in;

  always_comb begin
    match = 1'b0;
    case (filt_mode)
      FILT_ALL:  match = 1'b1;
      FILT_MEMW: match = memwrite_in;
      FILT_BR:   match = taken;
      FILT_REGW: match = regwrite_in;
      default:   match = 1'b0;
    endcase
  end

  assign push_req = retire_valid & trace_en & match;
  assign pop      = out_valid & out_ready;

  always_comb begin
    rec                   = '0;
    rec.pc                = pc_in;
    rec.instr             = instruction_in;
    rec.data              = memwrite_in ? store_data_in : alu_result_in;
    rec.flags[FLAG_TAKEN] = taken;
    rec.flags[FLAG_BR]    = branch_in;
    rec.flags[FLAG_MEMW]  = memwrite_in;
    rec.flags[FLAG_REGW]  = regwrite_in;
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Only reset touches the timestamp; clear leaves it running.
  always_ff @(posedge clk) begin
    if (!reset)
      ts_q <= '0;
    else
      ts_q <= ts_q + 1'b1;
  end

  assign wdata  = {ts_q, rec};
  assign out_ts = head[REC_W +: TS_W];
`else
  assign wdata  = rec;
  assign out_ts = '0;
`endif

  spim_trace_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push_req),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign head_rec  = trace_rec_t'(head[REC_W-1:0]);
  assign out_valid = ~empty;
  assign out_pc    = head_rec.pc;
  assign out_instr = head_rec.instr;
  assign out_data  = head_rec.data;
  assign out_flags = head_rec.flags;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push_req && full && !pop) begin
      overflow <= 1'b1;
      if (drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_spim_trace_buffer.sv
// Directed self-checking bench for spim_trace_buffer (DEPTH=16); checks out_ts deltas when TRACE_TIMESTAMP_EN is set.
module tb_spim_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        retire_valid;
  logic [9:0]  pc_in;
  logic [31:0] instruction_in, alu_result_in, store_data_in;
  logic        branch_in, zero_in, memwrite_in, regwrite_in;
  logic        trace_en;
  logic [1:0]  filt_mode;
  logic        clear;
  logic        out_valid, out_ready;
  logic [9:0]  out_pc;
  logic [31:0] out_instr, out_data;
  logic [3:0]  out_flags;
  logic [23:0] out_ts;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spim_trace_buffer #(.DEPTH(16), .DROP_W(16), .TS_W(24)) dut (
    .clk            (clk),
    .reset          (reset),
    .retire_valid   (retire_valid),
    .pc_in          (pc_in),
    .instruction_in (instruction_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .branch_in      (branch_in),
    .zero_in        (zero_in),
    .memwrite_in    (memwrite_in),
    .regwrite_in    (regwrite_in),
    .trace_en       (trace_en),
    .filt_mode      (filt_mode),
    .clear          (clear),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_data       (out_data),
    .out_flags      (out_flags),
    .out_ts         (out_ts),
    .fill           (fill),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one retire for exactly one edge; leaves fields set, strobe low.
  task automatic retire(input logic [9:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                        input logic br, input logic z, input logic mw, input logic rw);
    retire_valid   = 1'b1;
    pc_in          = pc;
    instruction_in = 32'h1000_0000 | 32'(pc);
    alu_result_in  = alu;
    store_data_in  = sd;
    branch_in      = br;
    zero_in        = z;
    memwrite_in    = mw;
    regwrite_in    = rw;
    tick();
    retire_valid   = 1'b0;
  endtask

  initial begin
    logic [23:0] ts_a;
    reset = 1'b0; retire_valid = 1'b0; pc_in = '0; instruction_in = '0;
    alu_result_in = '0; store_data_in = '0; branch_in = 1'b0; zero_in = 1'b0;
    memwrite_in = 1'b0; regwrite_in = 1'b0; trace_en = 1'b1; filt_mode = 2'b00;
    clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_data", out_data, 0);
    reset = 1'b1;
    tick();

    // Capture-all with ready high: each record shows up one cycle after its retire.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire(10'(4 * i), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("all_valid", out_valid, 1);
      chk("all_pc", out_pc, 64'(4 * i));
      chk("all_instr", out_instr, 64'h1000_0000 + 64'(4 * i));
      chk("all_data", out_data, 64'h100 + 64'(i));
      chk("all_flags", out_flags, 4'b0001);
    end
    tick();
    chk("all_fill0", fill, 0);
    chk("all_valid0", out_valid, 0);

    // Memwrite-only filter: stores report store data.
    out_ready = 1'b0;
    filt_mode = 2'b01;
    retire(10'h0c, 32'h10, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1);
    retire(10'h10, 32'h14, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    retire(10'h14, 32'h18, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1);
    retire(10'h18, 32'h1c, 32'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("memw_fill", fill, 2);
    out_ready = 1'b1;
    chk("memw_data0", out_data, 32'hAA);
    chk("memw_flags0", out_flags, 4'b0010);
    tick();
    chk("memw_data1", out_data, 32'hBB);
    chk("memw_pc1", out_pc, 10'h18);
    tick();
    chk("memw_empty", out_valid, 0);

    // Taken-branch filter.
    out_ready = 1'b0;
    filt_mode = 2'b10;
    retire(10'h20, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    retire(10'h24, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_fill", fill, 1);
    chk("br_pc", out_pc, 10'h20);
    chk("br_flags", out_flags, 4'b1100);
    out_ready = 1'b1;
    tick();
    chk("br_drain", fill, 0);

    // Overflow: 20 retires into 16 entries.
    out_ready = 1'b0;
    filt_mode = 2'b00;
    for (int i = 0; i < 20; i++)
      retire(10'(4 * i), 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_fill", fill, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 4);
    chk("ovf_head", out_pc, 0);
    out_ready = 1'b1;
    retire(10'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("pp_fill", fill, 16);
    chk("pp_drop", drop_count, 4);
    chk("pp_head", out_pc, 10'h004);

    // Backpressure keeps the head stable.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pc", out_pc, 10'h004);
      chk("bp_data", out_data, 32'h1);
    end

    // Clear wins over a simultaneous retire.
    clear = 1'b1;
    retire(10'h200, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    chk("clr_fill", fill, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_drop", drop_count, 0);
    chk("clr_ovf", overflow, 0);
    tick();
    chk("clr_norec", fill, 0);

    // Disabled capture is neither stored nor counted as a drop.
    trace_en = 1'b0;
    retire(10'h204, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_fill", fill, 0);
    chk("dis_drop", drop_count, 0);
    trace_en = 1'b1;

    // Timestamp: two retires seven edges apart.
    retire(10'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    retire(10'h304, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ts_fill", fill, 2);
    ts_a = out_ts;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ts_pc", out_pc, 10'h304);
`ifdef TRACE_TIMESTAMP_EN
    chk("ts_delta", 24'(out_ts - ts_a), 7);
`else
    chk("ts_zero_a", ts_a, 0);
    chk("ts_zero_b", out_ts, 0);
`endif

    // Reset mid-drain drops the presented record.
    chk("mid_valid", out_valid, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_pc", out_pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
